// File: rtl/lane_hit_judge.sv
// Multi-lane button judge: per-lane synchroniser, debouncer and hit-window FSM,
// with a global saturating combo counter and score counter.
module lane_hit_judge #(
  parameter int unsigned LANES           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned COMBO_W         = 8,
  parameter int unsigned SCORE_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES-1:0]   button_in,
  input  logic [LANES-1:0]   note_window,
  output logic [LANES-1:0]   hit_pulse,
  output logic [LANES-1:0]   miss_pulse,
  output logic [LANES-1:0]   stray_pulse,
  output logic [COMBO_W-1:0] combo,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned H_W   = $clog2(LANES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_HIT,
    S_WAIT,
    S_MISS,
    S_STRAY,
    S_STRAY_W
  } state_t;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic             sync1_q, sync2_q;
    logic             db_q, db_d, db_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press;
    state_t           state_q, state_d;

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d  = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign press = db_q & ~db_prev_q;

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        S_IDLE: begin
          if (note_window[l])   state_d = S_OPEN;
          else if (press)       state_d = S_STRAY;
        end
        S_OPEN: begin
          if (press)            state_d = S_HIT;
          else if (!note_window[l]) state_d = S_MISS;
        end
        S_HIT:     state_d = note_window[l] ? S_WAIT : S_IDLE;
        S_WAIT: begin
          if (press)            state_d = S_STRAY_W;
          else if (!note_window[l]) state_d = S_IDLE;
        end
        S_MISS:    state_d = note_window[l] ? S_OPEN : S_IDLE;
        S_STRAY:   state_d = note_window[l] ? S_OPEN : S_IDLE;
        S_STRAY_W: state_d = note_window[l] ? S_WAIT : S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        cnt_q     <= '0;
        state_q   <= S_IDLE;
      end else begin
        sync1_q   <= button_in[l];
        sync2_q   <= sync1_q;
        db_q      <= db_d;
        db_prev_q <= db_q;
        cnt_q     <= cnt_d;
        state_q   <= state_d;
      end
    end

    assign hit_pulse[l]   = (state_q == S_HIT);
    assign miss_pulse[l]  = (state_q == S_MISS);
    assign stray_pulse[l] = (state_q == S_STRAY) || (state_q == S_STRAY_W);
  end

  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [H_W-1:0]     h;
  logic [COMBO_W:0]   combo_sum;
  logic [SCORE_W:0]   score_sum;

  // Sums are one bit wider so the carry-out selects saturation.
  always_comb begin
    h = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      h = h + H_W'(hit_pulse[i]);
    end
    combo_sum = {1'b0, combo_q} + (COMBO_W + 1)'(h);
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(h);
    combo_d   = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    if ((|miss_pulse) || (|stray_pulse)) begin
      combo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      combo_q <= '0;
      score_q <= '0;
    end else begin
      combo_q <= combo_d;
      score_q <= score_d;
    end
  end

  assign combo = combo_q;
  assign score = score_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Scoreboard bench for lane_hit_judge: stimulus pushes expected pulse events,
// a negedge monitor pops and compares them plus the following combo/score.
module tb_lane_hit_judge;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] win;
  logic [3:0] hit_pulse, miss_pulse, stray_pulse;
  logic [7:0] combo;
  logic [15:0] score;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] hit;
    logic [3:0] miss;
    logic [3:0] stray;
    int         combo;
    int         score;
  } exp_t;

  exp_t sb[$];

  logic chk_pending = 1'b0;
  int   chk_combo, chk_score;

  lane_hit_judge #(
    .LANES(4),
    .DEBOUNCE_CYCLES(3),
    .COMBO_W(8),
    .SCORE_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_in(btn),
    .note_window(win),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .stray_pulse(stray_pulse),
    .combo(combo),
    .score(score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [3:0] h, input logic [3:0] m,
                      input logic [3:0] s, input int cb, input int sc);
    exp_t e;
    e.cyc = c; e.hit = h; e.miss = m; e.stray = s; e.combo = cb; e.score = sc;
    sb.push_back(e);
  endtask

  // Press lanes in mask m inside open windows; HIT appears 6 edges after the press is driven.
  task automatic hit_multi(input logic [3:0] m, input int cb, input int sc);
    int t;
    win = win | m;
    tick(2);
    t = cyc;
    btn = btn | m;
    push(t + 6, m, 4'b0000, 4'b0000, cb, sc);
    tick(8);
    btn = btn & ~m;
    tick(6);
    win = win & ~m;
    tick(3);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_pending) begin
      check("combo_after_pulse", combo, chk_combo);
      check("score_after_pulse", score, chk_score);
      chk_pending = 1'b0;
    end
    if ((hit_pulse | miss_pulse | stray_pulse) != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {20'b0, hit_pulse, miss_pulse, stray_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("hit_pulse", hit_pulse, e.hit);
        check("miss_pulse", miss_pulse, e.miss);
        check("stray_pulse", stray_pulse, e.stray);
        chk_pending = 1'b1;
        chk_combo   = e.combo;
        chk_score   = e.score;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1;
    btn   = 4'b0000;
    win   = 4'b0000;
    tick(3);
    check("reset_hit", hit_pulse, 0);
    check("reset_miss", miss_pulse, 0);
    check("reset_stray", stray_pulse, 0);
    check("reset_combo", combo, 0);
    check("reset_score", score, 0);
    reset = 1'b0;
    tick(2);

    // Lane 0 hits, building combo to 5; no miss when the window closes after a hit.
    hit_multi(4'b0001, 1, 1);
    hit_multi(4'b0001, 2, 2);
    hit_multi(4'b0001, 3, 3);
    hit_multi(4'b0001, 4, 4);
    hit_multi(4'b0001, 5, 5);

    // Lane 1 window with no press: miss on the edge after it falls.
    win[1] = 1'b1;
    tick(20);
    t = cyc;
    win[1] = 1'b0;
    push(t + 1, 4'b0000, 4'b0010, 4'b0000, 0, 5);
    tick(4);

    // Lane 2: 2-cycle glitch rejected, 3-cycle glitch accepted.
    win[2] = 1'b1;
    tick(2);
    btn[2] = 1'b1;
    tick(2);
    btn[2] = 1'b0;
    tick(10);
    t = cyc;
    btn[2] = 1'b1;
    push(t + 6, 4'b0100, 4'b0000, 4'b0000, 1, 6);
    tick(3);
    btn[2] = 1'b0;
    tick(12);
    win[2] = 1'b0;
    tick(3);

    // Lane 3 stray with no window.
    t = cyc;
    btn[3] = 1'b1;
    push(t + 6, 4'b0000, 4'b0000, 4'b1000, 0, 6);
    tick(10);
    btn[3] = 1'b0;
    tick(8);

    // Lane 3 hit, then a second press inside WAIT is a stray.
    win[3] = 1'b1;
    tick(2);
    t = cyc;
    btn[3] = 1'b1;
    push(t + 6, 4'b1000, 4'b0000, 4'b0000, 1, 7);
    tick(8);
    btn[3] = 1'b0;
    tick(8);
    t = cyc;
    btn[3] = 1'b1;
    push(t + 6, 4'b0000, 4'b0000, 4'b1000, 0, 7);
    tick(10);
    btn[3] = 1'b0;
    tick(8);
    win[3] = 1'b0;
    tick(3);

    // Build combo to 253, then a 4-lane hit saturates at 255.
    hit_multi(4'b0001, 1, 8);
    for (int k = 1; k <= 63; k++) begin
      hit_multi(4'b1111, 1 + 4 * k, 8 + 4 * k);
    end
    hit_multi(4'b1111, 255, 264);

    // Lanes 1-3 hit on the same edge lane 0 misses.
    win = 4'b1111;
    tick(2);
    t = cyc;
    btn = 4'b1110;
    tick(5);
    win[0] = 1'b0;
    push(t + 6, 4'b1110, 4'b0001, 4'b0000, 0, 267);
    tick(3);
    btn = 4'b0000;
    tick(6);
    win = 4'b0000;
    tick(3);

    // Reset mid-window with the button held; it becomes a stray after release.
    win[0] = 1'b1;
    tick(2);
    btn[0] = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("midreset_hit", hit_pulse, 0);
    check("midreset_miss", miss_pulse, 0);
    check("midreset_stray", stray_pulse, 0);
    check("midreset_combo", combo, 0);
    check("midreset_score", score, 0);
    win[0] = 1'b0;
    tick(2);
    t = cyc;
    reset = 1'b0;
    push(t + 6, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    tick(10);
    btn = 4'b0000;
    tick(10);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
